uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
Parametrised next-generation UART receiver, successor to uart_rx. Adds configurable data width, optional parity, and 1 or 2 stop bits. Adds an input synchroniser, start-bit glitch rejection, and framing/parity error reporting. Sits between the board RX pin and byte-consuming logic, in the same clock domain as uart_tx.

Parameters:
CLKS_PER_BIT, 87, clocks per bit (10 MHz / 115200); legal range 8..65535.
DATA_BITS, 8, data bits per frame; legal range 5..9.
PARITY_MODE, 0, parity mode: 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, stop bits; legal values 1 or 2.

Ports:
i_Clock  input  1  system clock; all logic on the rising edge.
i_Reset  input  1  asynchronous, active-high reset.
i_Rx_Serial  input  1  asynchronous serial line; idles high.
o_Rx_DV  output  1  one-cycle pulse when a frame completes.
o_Rx_Byte  output  DATA_BITS  received data, LSB first on the wire.
o_Parity_Err  output  1  parity mismatch; valid only while o_Rx_DV=1.
o_Frame_Err  output  1  a stop bit sampled low; valid only while o_Rx_DV=1.
o_Busy  output  1  high in every state except IDLE.

Behaviour:
- Reset and clocking: one clock (i_Clock); reset is asynchronous and active-high (i_Reset).
- Reset values: o_Rx_DV=0, o_Rx_Byte=0, o_Parity_Err=0, o_Frame_Err=0, o_Busy=0, state=IDLE, counters=0, synchroniser flops=1.
- Synchroniser: i_Rx_Serial passes through 2 flops to form rx_s; all decisions use rx_s, which adds 2 cycles of latency.
- Bit counter: width $clog2(CLKS_PER_BIT). Index counter: width $clog2(DATA_BITS+1).
- IDLE: rx_s=0 -> START, clear the clock counter.
- START: count to (CLKS_PER_BIT-1)/2 (mid-bit).
  - rx_s still 0 -> DATA, clear counters.
  - rx_s=1 -> glitch; return to IDLE with no outputs.
- DATA: at each count CLKS_PER_BIT-1, sample rx_s into shift position bit_idx and clear the counter.
  - After DATA_BITS samples: -> PARITY if PARITY_MODE!=0, else -> STOP.
- PARITY: sample at CLKS_PER_BIT-1.
  - Expected bit = XOR of the data bits for even mode; its inverse for odd mode.
  - Mismatch sets an internal parity-error flag.
- STOP: sample STOP_BITS times, each at CLKS_PER_BIT-1; any 0 sample sets an internal frame-error flag.
- After the last stop sample, in the next cycle:
  - o_Rx_DV=1 for exactly 1 cycle.
  - o_Rx_Byte loads the shift register.
  - o_Parity_Err and o_Frame_Err present the internal flags.
- Next state after the final stop sample:
  - No frame error -> IDLE immediately (mid-stop-bit), allowing back-to-back frames.
  - Frame error -> WAIT_HIGH.
- WAIT_HIGH: stays until rx_s=1, then -> IDLE. A break (line held low) yields exactly one DV with o_Frame_Err=1, and no retrigger.
- Hold rules: o_Rx_Byte holds until the next DV. Error outputs are 0 whenever o_Rx_DV=0.
- Error frames: DV is still asserted and the byte is delivered; the consumer decides whether to discard it.
- Back-to-back frames: no idle time required between stop bit and next start bit. Tolerance is ±2% baud mismatch at 8N1.
- Reset mid-frame: immediate return to IDLE, no DV, partial data discarded.

Optional Feature:
UART_RX_MAJORITY_EN
- Defined: each data, parity and stop sample is the 2-of-3 majority of rx_s at counts CLKS_PER_BIT-2, -1 and the sample point (START check likewise). A one-cycle glitch at mid-bit is rejected. Adds no extra latency to DV.
- Undefined: each bit uses a single sample at the sample point.

Decomposition:
- Package uart_pkg:
  - Parity constants PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2.
  - rx_state_t enum: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - Helper function clog2_min1.
- Sub-module uart_rx_sync: parametrised N-flop (default 2) synchroniser with reset value 1. Reusable by later RX blocks.

Test Plan:
(All at 10 MHz, CLKS_PER_BIT=87, bit period 8700 ns.)
1. 8N1, send 0xAB -> exactly one o_Rx_DV pulse, o_Rx_Byte=0xAB, both error flags 0, o_Busy back to 0.
2. 8E1, send 0x32 with parity bit 1 (correct is 1: three ones, so even parity requires 1) -> DV, byte 0x32, no error. Resend with parity bit 0 -> DV, byte 0x32, o_Parity_Err=1.
3. 8N1, send 0x55 with stop bit 0, then hold the line low 5 bit periods -> one DV with o_Frame_Err=1. No second DV until the line goes high and a new start bit arrives.
4. Low pulse of 20 clocks on an idle line -> no DV, o_Busy returns to 0 within 44 clocks.
5. 7O2 (DATA_BITS=7, PARITY_MODE=1, STOP_BITS=2), send 0x41 then 0x7F back-to-back -> two DVs, bytes 0x41 and 0x7F, no errors.
6. Assert i_Reset for 1 cycle during bit 4 of a frame -> all outputs 0 at once, no DV. The next clean frame 0xC3 is received correctly. With UART_RX_MAJORITY_EN, also send 0xA5 with a 1-cycle inverted glitch at every data-bit midpoint -> o_Rx_Byte=0xA5.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receiver types, parity constants and width helper
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  // Counter width that never collapses to zero bits for tiny ranges.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - N-flop synchroniser for an idle-high asynchronous serial line
module uart_rx_sync #(
  parameter int N = 2
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_D,
  output logic o_Q
);

  logic [N-1:0] sync_q;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[N-2:0], i_D};
    end
  end

  assign o_Q = sync_q[N-1];

endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver with parity, stop-bit and glitch checks
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling of every bit.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Busy
);

  import uart_pkg::*;

  localparam int CNT_W = clog2_min1(CLKS_PER_BIT);
  localparam int IDX_W = clog2_min1(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID   = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = (STOP_BITS == 2);

  logic rx_s;
  logic sample;

  rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 frm_q, frm_d;
  logic                 dv_q, dv_d;
  logic [DATA_BITS-1:0] byte_q, byte_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 exp_par;
  logic                 frame_now;

  uart_rx_sync #(.N(2)) u_sync (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_D     (i_Rx_Serial),
    .o_Q     (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // rx_s from the two cycles before the sample point, voted with the current one.
  logic [1:0] hist_q;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], rx_s};
    end
  end

  assign sample = (rx_s & hist_q[0]) | (rx_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
  assign sample = rx_s;
`endif

  assign exp_par   = (PARITY_MODE == PAR_ODD) ? ~^shift_q : ^shift_q;
  assign frame_now = frm_q | ~sample;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    par_d   = par_q;
    frm_d   = frm_q;
    dv_d    = 1'b0;
    byte_d  = byte_q;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end

      START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d = '0;
          if (!sample) begin
            state_d = DATA;
            idx_d   = '0;
            stop_d  = 1'b0;
            par_d   = 1'b0;
            frm_d   = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          // LSB arrives first, so it ends up in bit 0 after DATA_BITS shifts.
          shift_d = {sample, shift_q[DATA_BITS-1:1]};
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          par_d   = (sample != exp_par);
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (stop_q == STOP_LAST) begin
            dv_d    = 1'b1;
            byte_d  = shift_q;
            perr_d  = par_q;
            ferr_d  = frame_now;
            frm_d   = frame_now;
            stop_d  = 1'b0;
            // Leaving mid-stop-bit lets a back-to-back start bit be caught.
            state_d = frame_now ? WAIT_HIGH : IDLE;
          end else begin
            stop_d = 1'b1;
            frm_d  = frame_now;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      WAIT_HIGH: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      par_q   <= 1'b0;
      frm_q   <= 1'b0;
      dv_q    <= 1'b0;
      byte_q  <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      frm_q   <= frm_d;
      dv_q    <= dv_d;
      byte_q  <= byte_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign o_Rx_DV      = dv_q;
  assign o_Rx_Byte    = byte_q;
  assign o_Parity_Err = perr_q;
  assign o_Frame_Err  = ferr_q;
  assign o_Busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - self-checking bench for uart_rx_param in 8N1, 8E1 and 7O2 builds
module tb_uart_rx_param;

  localparam int CPB = 87;

  logic clk;
  logic rst;
  logic rx0, rx1, rx2;

  logic       dv0, perr0, ferr0, busy0;
  logic [7:0] byte0;
  logic       dv1, perr1, ferr1, busy1;
  logic [7:0] byte1;
  logic       dv2, perr2, ferr2, busy2;
  logic [6:0] byte2;

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } rec_t;

  rec_t q0[$];
  rec_t q1[$];
  rec_t q2[$];

  int total = 0;
  int bad   = 0;
  int stray = 0;

  initial clk = 1'b0;
  always #50 clk = ~clk;

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx0), .o_Rx_DV(dv0), .o_Rx_Byte(byte0),
    .o_Parity_Err(perr0), .o_Frame_Err(ferr0), .o_Busy(busy0));

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u_8e1 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx1), .o_Rx_DV(dv1), .o_Rx_Byte(byte1),
    .o_Parity_Err(perr1), .o_Frame_Err(ferr1), .o_Busy(busy1));

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2)) u_7o2 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx2), .o_Rx_DV(dv2), .o_Rx_Byte(byte2),
    .o_Parity_Err(perr2), .o_Frame_Err(ferr2), .o_Busy(busy2));

  // Collect every delivered frame; error flags outside a DV are tallied as stray.
  always @(negedge clk) begin
    if (dv0 === 1'b1) q0.push_back({1'b0, byte0, perr0, ferr0});
    else if ((perr0 | ferr0) !== 1'b0) stray++;
    if (dv1 === 1'b1) q1.push_back({1'b0, byte1, perr1, ferr1});
    else if ((perr1 | ferr1) !== 1'b0) stray++;
    if (dv2 === 1'b1) q2.push_back({2'b00, byte2, perr2, ferr2});
    else if ((perr2 | ferr2) !== 1'b0) stray++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int qsize(input int sel);
    case (sel)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic set_line(input int sel, input logic v);
    case (sel)
      0:       rx0 = v;
      1:       rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  task automatic idle(input int sel, input int n);
    set_line(sel, 1'b1);
    repeat (n) @(negedge clk);
  endtask

  // Reference framing: start 0, data LSB first, optional parity, stop bits.
  task automatic send_frame(input int sel, input logic [8:0] data, input int dbits,
                            input int pmode, input int nstop, input bit flip_par,
                            input bit bad_stop, input bit glitch);
    logic bits[$];
    logic par;
    int   ones;
    bits.push_back(1'b0);
    for (int i = 0; i < dbits; i++) bits.push_back(data[i]);
    if (pmode != 0) begin
      ones = $countones(data & 9'((1 << dbits) - 1));
      par  = (pmode == 2) ? logic'(ones % 2) : logic'(!(ones % 2));
      bits.push_back(par ^ flip_par);
    end
    for (int s = 0; s < nstop; s++) bits.push_back(!(bad_stop && s == nstop - 1));
    for (int b = 0; b < bits.size(); b++) begin
      for (int c = 0; c < CPB; c++) begin
        set_line(sel, (glitch && b >= 1 && b <= dbits && c == 43) ? ~bits[b] : bits[b]);
        @(negedge clk);
      end
    end
  endtask

  task automatic pop_check(input int sel, input logic [8:0] data, input logic pe,
                           input logic fe, input string tag);
    rec_t r;
    chk({tag, "_dv"}, 32'(qsize(sel) > 0), 32'd1);
    if (qsize(sel) > 0) begin
      case (sel)
        0:       r = q0.pop_front();
        1:       r = q1.pop_front();
        default: r = q2.pop_front();
      endcase
      chk({tag, "_byte"}, 32'(r.data), 32'(data));
      chk({tag, "_perr"}, 32'(r.perr), 32'(pe));
      chk({tag, "_ferr"}, 32'(r.ferr), 32'(fe));
    end
  endtask

  initial begin
    int         found;
    int         dbits, pm, ns;
    logic [8:0] d;
    bit         fp, bs;

    rst = 1'b1;
    rx0 = 1'b1;
    rx1 = 1'b1;
    rx2 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_dv",   32'(dv0),   32'd0);
    chk("rst_byte", 32'(byte0), 32'd0);
    chk("rst_perr", 32'(perr0), 32'd0);
    chk("rst_ferr", 32'(ferr0), 32'd0);
    chk("rst_busy", 32'(busy0 | busy1 | busy2), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    send_frame(0, 9'hAB, 8, 0, 1, 0, 0, 0);
    idle(0, CPB);
    chk("t1_count", 32'(qsize(0)), 32'd1);
    pop_check(0, 9'hAB, 1'b0, 1'b0, "t1");
    chk("t1_busy", 32'(busy0), 32'd0);

    send_frame(1, 9'h32, 8, 2, 1, 0, 0, 0);
    idle(1, CPB);
    pop_check(1, 9'h32, 1'b0, 1'b0, "t2_good");
    send_frame(1, 9'h32, 8, 2, 1, 1, 0, 0);
    idle(1, CPB);
    pop_check(1, 9'h32, 1'b1, 1'b0, "t2_bad");

    send_frame(0, 9'h55, 8, 0, 1, 0, 1, 0);
    set_line(0, 1'b0);
    repeat (5 * CPB) @(negedge clk);
    chk("t3_count", 32'(qsize(0)), 32'd1);
    chk("t3_busy_low", 32'(busy0), 32'd1);
    pop_check(0, 9'h55, 1'b0, 1'b1, "t3");
    idle(0, 2 * CPB);
    chk("t3_no_retrigger", 32'(qsize(0)), 32'd0);
    send_frame(0, 9'h3C, 8, 0, 1, 0, 0, 0);
    idle(0, CPB);
    pop_check(0, 9'h3C, 1'b0, 1'b0, "t3_next");

    set_line(0, 1'b0);
    repeat (20) @(negedge clk);
    set_line(0, 1'b1);
    found = 0;
    for (int i = 0; i < 44 && found == 0; i++) begin
      @(negedge clk);
      if (busy0 === 1'b0) found = 1;
    end
    chk("t4_busy_return", 32'(found), 32'd1);
    idle(0, 2 * CPB);
    chk("t4_no_dv", 32'(qsize(0)), 32'd0);
    chk("t4_byte_hold", 32'(byte0), 32'h3C);

    send_frame(2, 9'h41, 7, 1, 2, 0, 0, 0);
    send_frame(2, 9'h7F, 7, 1, 2, 0, 0, 0);
    idle(2, CPB);
    chk("t5_count", 32'(qsize(2)), 32'd2);
    pop_check(2, 9'h41, 1'b0, 1'b0, "t5_a");
    pop_check(2, 9'h7F, 1'b0, 1'b0, "t5_b");

    for (int k = 0; k < 4; k++) begin
      for (int sel = 0; sel < 3; sel++) begin
        dbits = (sel == 2) ? 7 : 8;
        pm    = (sel == 0) ? 0 : ((sel == 1) ? 2 : 1);
        ns    = (sel == 2) ? 2 : 1;
        d     = 9'($urandom) & 9'((1 << dbits) - 1);
        fp    = ($urandom_range(0, 3) == 0);
        bs    = ($urandom_range(0, 3) == 0);
        send_frame(sel, d, dbits, pm, ns, fp, bs, 0);
        idle(sel, CPB);
        chk("rand_count", 32'(qsize(sel)), 32'd1);
        pop_check(sel, d, logic'(fp && pm != 0), logic'(bs), "rand");
      end
    end

    d = 9'h5A;
    set_line(0, 1'b0);
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      set_line(0, d[i]);
      repeat (CPB) @(negedge clk);
    end
    set_line(0, d[4]);
    repeat (40) @(negedge clk);
    rst = 1'b1;
    set_line(0, 1'b1);
    #1;
    chk("t6_dv",   32'(dv0),   32'd0);
    chk("t6_byte", 32'(byte0), 32'd0);
    chk("t6_err",  32'(perr0 | ferr0), 32'd0);
    chk("t6_busy", 32'(busy0), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(0, 12 * CPB);
    chk("t6_no_dv", 32'(qsize(0)), 32'd0);
    send_frame(0, 9'hC3, 8, 0, 1, 0, 0, 0);
    idle(0, CPB);
    pop_check(0, 9'hC3, 1'b0, 1'b0, "t6_next");

`ifdef UART_RX_MAJORITY_EN
    send_frame(0, 9'hA5, 8, 0, 1, 0, 0, 1);
    idle(0, CPB);
    pop_check(0, 9'hA5, 1'b0, 1'b0, "maj_glitch");
`endif

    chk("stray_err_flags", 32'(stray), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
